// File: rtl/normalize_pipe.sv
// Two-stage mantissa normalizer: S1 registers mantissa/exponent/leading-zero count, S2 the shifted result.
// Latency 2 edges, one word per cycle; valid/ready on both sides with outReady combinationally feeding inReady.

module lzc_tree #(
  parameter int WIDTH      = 16,
  parameter int ADD_OFFSET = 0
) (
  input  logic [WIDTH-1:0]           vec_i,
  output logic [$clog2(WIDTH+1)-1:0] lz_o
);
  localparam int LVLS = $clog2(WIDTH);
  localparam int P    = 1 << LVLS;
  localparam int CW   = LVLS + 1;
  localparam int SW   = $clog2(WIDTH + 1);

  logic [P-1:0]  pad;
  logic          all_z [1:2*P-1];
  logic [CW-1:0] cnt   [1:2*P-1];
  logic [CW-1:0] size  [1:2*P-1];

  // Heap-ordered tree: node k has children 2k (more significant) and 2k+1.
  always_comb begin
    pad = '0;
    pad[P-1 -: WIDTH] = vec_i;
    for (int k = 1; k < 2*P; k++) begin
      all_z[k] = 1'b0;
      cnt[k]   = '0;
      size[k]  = '0;
    end
    for (int i = 0; i < P; i++) begin
      all_z[P+i] = ~pad[P-1-i];
      size[P+i]  = CW'(1);
    end
    for (int k = P - 1; k >= 1; k--) begin
      all_z[k] = all_z[2*k] & all_z[2*k+1];
      size[k]  = size[2*k] << 1;
      cnt[k]   = all_z[2*k] ? size[2*k] + cnt[2*k+1] : cnt[2*k];
    end
  end

  assign lz_o = SW'(all_z[1] ? CW'(WIDTH) : cnt[1]) + SW'(ADD_OFFSET);
endmodule

module normalize_pipe #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [WIDTH-1:0]           inMant,
  input  logic [EXP_WIDTH-1:0]       inExp,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [WIDTH-1:0]           outMant,
  output logic [EXP_WIDTH-1:0]       outExp,
  output logic [$clog2(WIDTH+1)-1:0] outShift,
  output logic                       outZero,
  output logic                       outUnderflow
);
  localparam int SW   = $clog2(WIDTH + 1);
  localparam int CMPW = (SW > EXP_WIDTH) ? SW : EXP_WIDTH;

  logic                 s1_vld_q, s2_vld_q;
  logic [WIDTH-1:0]     s1_mant_q;
  logic [EXP_WIDTH-1:0] s1_exp_q;
  logic [SW-1:0]        s1_lz_q;
  logic [SW-1:0]        lz_in;

  logic [WIDTH-1:0]     out_mant_q, out_mant_d;
  logic [EXP_WIDTH-1:0] out_exp_q, out_exp_d;
  logic [SW-1:0]        out_shift_q, out_shift_d;
  logic                 out_zero_q, out_zero_d;
  logic                 out_uf_q, out_uf_d;

  logic s1_ld, s2_ld, in_xfer;

  assign s2_ld   = ~s2_vld_q | outReady;
  assign s1_ld   = ~s1_vld_q | s2_ld;
  assign inReady = s1_ld & ~reset;
  assign in_xfer = inValid & inReady;

  lzc_tree #(.WIDTH(WIDTH), .ADD_OFFSET(0)) u_lzc (
    .vec_i (inMant),
    .lz_o  (lz_in)
  );

  // Shift is clamped to the exponent so the result never goes below exponent 0.
  always_comb begin
    out_zero_d  = (s1_mant_q == '0);
    out_uf_d    = ~out_zero_d && (CMPW'(s1_lz_q) > CMPW'(s1_exp_q));
    out_shift_d = out_uf_d ? SW'(s1_exp_q) : s1_lz_q;
    if (out_zero_d) out_shift_d = '0;
    out_mant_d  = s1_mant_q << out_shift_d;
    out_exp_d   = out_zero_d ? '0 : s1_exp_q - EXP_WIDTH'(out_shift_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_mant_q <= '0;
      s1_exp_q  <= '0;
      s1_lz_q   <= '0;
    end else begin
      if (s1_ld) s1_vld_q <= in_xfer;
      if (in_xfer) begin
        s1_mant_q <= inMant;
        s1_exp_q  <= inExp;
        s1_lz_q   <= lz_in;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_vld_q    <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_shift_q <= '0;
      out_zero_q  <= 1'b0;
      out_uf_q    <= 1'b0;
    end else if (s2_ld) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_mant_q  <= out_mant_d;
        out_exp_q   <= out_exp_d;
        out_shift_q <= out_shift_d;
        out_zero_q  <= out_zero_d;
        out_uf_q    <= out_uf_d;
      end
    end
  end

  assign outValid     = s2_vld_q;
  assign outMant      = out_mant_q;
  assign outExp       = out_exp_q;
  assign outShift     = out_shift_q;
  assign outZero      = out_zero_q;
  assign outUnderflow = out_uf_q;
endmodule

// File: tb/tb_normalize_pipe.sv
// Directed and streaming checks of normalize_pipe at WIDTH=16, EXP_WIDTH=8.
module tb_normalize_pipe;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] inMant = '0;
  logic [7:0]  inExp = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] outMant;
  logic [7:0]  outExp;
  logic [4:0]  outShift;
  logic        outZero;
  logic        outUnderflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [30:0] exp_q[$];

  normalize_pipe #(.WIDTH(16), .EXP_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .inValid(inValid), .inReady(inReady), .inMant(inMant), .inExp(inExp),
    .outValid(outValid), .outReady(outReady), .outMant(outMant), .outExp(outExp),
    .outShift(outShift), .outZero(outZero), .outUnderflow(outUnderflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: {mant, exp, shift, zero, underflow}
  function automatic logic [30:0] model(input logic [15:0] m, input logic [7:0] e);
    int lz;
    int sh;
    logic [15:0] mo;
    logic [7:0]  eo;
    lz = 16;
    for (int i = 0; i < 16; i++) if (m[i]) lz = 15 - i;
    if (m == 16'h0) return {16'h0, 8'h0, 5'h0, 1'b1, 1'b0};
    sh = (lz <= int'(e)) ? lz : int'(e);
    mo = m << sh;
    eo = 8'(int'(e) - sh);
    return {mo, eo, 5'(sh), 1'b0, (lz > int'(e)) ? 1'b1 : 1'b0};
  endfunction

  task automatic send_check(input string name, input logic [15:0] m, input logic [7:0] e,
                            input logic [15:0] em, input logic [7:0] ee, input logic [4:0] es,
                            input logic ez, input logic eu);
    @(negedge clock);
    outReady = 1'b1; inValid = 1'b1; inMant = m; inExp = e;
    #1 chk({name, " accept"}, inReady, 1);
    @(negedge clock);
    inValid = 1'b0;
    #1 chk({name, " not_yet"}, outValid, 0);
    @(negedge clock);
    #1;
    chk({name, " valid"}, outValid, 1);
    chk({name, " mant"}, outMant, em);
    chk({name, " exp"}, outExp, ee);
    chk({name, " shift"}, outShift, es);
    chk({name, " zero"}, outZero, ez);
    chk({name, " uf"}, outUnderflow, eu);
  endtask

  initial begin
    int sent;
    int recv;
    logic [15:0] m;
    logic [7:0]  e;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst outValid", outValid, 0);
    chk("rst inReady", inReady, 0);
    chk("rst outs", {outMant, outExp, outShift, outZero, outUnderflow}, 0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("post_rst inReady", inReady, 1);

    // Directed vectors
    send_check("lz15", 16'h0001, 8'd20, 16'h8000, 8'd5, 5'd15, 1'b0, 1'b0);
    send_check("uf", 16'h00F0, 8'd3, 16'h0780, 8'd0, 5'd3, 1'b0, 1'b1);
    send_check("zero", 16'h0000, 8'd77, 16'h0000, 8'd0, 5'd0, 1'b1, 1'b0);
    send_check("norm", 16'h8000, 8'd0, 16'h8000, 8'd0, 5'd0, 1'b0, 1'b0);
    send_check("lz_eq_exp", 16'h0001, 8'd15, 16'h8000, 8'd0, 5'd15, 1'b0, 1'b0);
    send_check("lz_gt_exp", 16'h0001, 8'd14, 16'h4000, 8'd0, 5'd14, 1'b0, 1'b1);
    send_check("sh1", 16'h4000, 8'd200, 16'h8000, 8'd199, 5'd1, 1'b0, 1'b0);

    // Back-pressure: A, B, C offered while outReady=0
    @(negedge clock);
    outReady = 1'b0; inValid = 1'b1; inMant = 16'h0001; inExp = 8'd20;
    #1 chk("bp offerA", inReady, 1);
    @(negedge clock);
    inMant = 16'h00F0; inExp = 8'd3;
    #1 chk("bp offerB", inReady, 1);
    @(negedge clock);
    inMant = 16'h4000; inExp = 8'd200;
    for (int c = 3; c <= 6; c++) begin
      #1;
      chk("bp offerC blocked", inReady, 0);
      chk("bp hold vld", outValid, 1);
      chk("bp hold A", {outMant, outExp, outShift}, {16'h8000, 8'd5, 5'd15});
      if (c < 6) @(negedge clock);
    end
    @(negedge clock);
    outReady = 1'b1;
    #1;
    chk("bp C accepted", inReady, 1);
    chk("bp out A", {outValid, outMant, outExp}, {1'b1, 16'h8000, 8'd5});
    @(negedge clock);
    inValid = 1'b0;
    #1 chk("bp out B", {outValid, outMant, outExp, outUnderflow}, {1'b1, 16'h0780, 8'd0, 1'b1});
    @(negedge clock);
    #1 chk("bp out C", {outValid, outMant, outExp}, {1'b1, 16'h8000, 8'd199});
    @(negedge clock);
    #1 chk("bp drained", outValid, 0);

    // Streaming 100 words
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 110; cyc++) begin
      @(negedge clock);
      outReady = 1'b1;
      if (sent < 100) begin
        m = 16'($urandom) >> $urandom_range(0, 16);
        e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
        inValid = 1'b1; inMant = m; inExp = e;
      end else begin
        inValid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc < 102) chk("stream one_per_cycle", outValid, 1);
      if (outValid) begin
        if (exp_q.size() == 0) chk("stream unexpected", outValid, 0);
        else chk("stream word", {outMant, outExp, outShift, outZero, outUnderflow}, exp_q.pop_front());
        recv++;
      end
      if (inValid && inReady) begin
        exp_q.push_back(model(inMant, inExp));
        sent++;
      end
    end
    chk("stream count", recv, 100);
    chk("stream leftover", exp_q.size(), 0);

    // Reset mid-operation with both stages full
    @(negedge clock);
    outReady = 1'b0; inValid = 1'b1; inMant = 16'h0003; inExp = 8'd40;
    @(negedge clock);
    inMant = 16'h0010; inExp = 8'd50;
    @(negedge clock);
    inValid = 1'b0;
    #1 chk("mid full", {outValid, inReady}, {1'b1, 1'b0});
    #1 reset = 1'b1;
    #1;
    chk("mid rst outValid", outValid, 0);
    chk("mid rst inReady", inReady, 0);
    chk("mid rst outs", {outMant, outExp, outShift, outZero, outUnderflow}, 0);
    @(negedge clock);
    reset = 1'b0; outReady = 1'b1;
    #1 chk("mid post_rst inReady", inReady, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1 chk("mid no stale word", outValid, 0);
    end
    send_check("mid next", 16'h0200, 8'd9, 16'h8000, 8'd3, 5'd6, 1'b0, 1'b0);
    @(negedge clock);
    #1 chk("mid only one", outValid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
